decode_sched: RTL and testbench
===============================

Name: decode_sched

Overview:
- Decode-stage scheduler between fetch and execute.
- Buffers fetched instructions in a 2-entry queue and presents the queue head to the external immediate generator.
- Registers the instruction, PC, returned immediate and split register/function fields into a decode output register under valid/ready handshakes.
- Handles pipeline flush and flags illegal opcodes.

Parameters:
- DWIDTH, 32, instruction and immediate width.
- AWIDTH, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- f_valid_i  in  1  fetch holds a valid instruction.
- f_ready_o  out  1  scheduler can accept a fetch instruction.
- f_pc_i  in  AWIDTH  fetch PC.
- f_insn_i  in  DWIDTH  fetch instruction.
- flush_i  in  1  discard all buffered and output-stage instructions.
- igen_opcode_o  out  7  opcode of queue head, to immediate generator.
- igen_insn_o  out  DWIDTH  queue head instruction, to immediate generator.
- igen_imm_i  in  32  combinational immediate returned for igen_insn_o.
- d_valid_o  out  1  decode output register valid.
- d_ready_i  in  1  execute accepts decode output.
- d_pc_o  out  AWIDTH  registered PC.
- d_insn_o  out  DWIDTH  registered instruction.
- d_imm_o  out  32  registered immediate.
- d_rd_o / d_rs1_o / d_rs2_o  out  5 each  insn[11:7] / [19:15] / [24:20].
- d_funct3_o  out  3  insn[14:12].
- d_funct7_o  out  7  insn[31:25].
- d_illegal_o  out  1  opcode not in legal set.

Behaviour:
- Reset (rst_n=0 at an edge): queue count=0, read/write pointers=0, d_valid_o=0, all d_* data outputs=0.
  - f_ready_o=1 in the first cycle after reset.
  - Reset mid-transfer drops everything; no partial state survives.
- Queue: 2 entries of {pc, insn}, 1-bit read and write pointers that wrap 1->0, count 0..2.
  - f_ready_o = (count != 2); combinational from count only.
  - Push when f_valid_i && f_ready_o && !flush_i.
- Igen drive: igen_opcode_o = head insn[6:0] and igen_insn_o = head insn when count>0; both are 0 when count=0.
- Output load condition: count>0 && (!d_valid_o || d_ready_i) && !flush_i.
  - On load: d_* take head pc, insn, igen_imm_i and the field slices; d_valid_o=1; queue pops.
  - Otherwise, if d_valid_o && d_ready_i, then d_valid_o=0 and d_* hold their values.
  - While d_valid_o && !d_ready_i, all d_* are stable.
- Simultaneous push and pop at count 1: count stays 1; pointers both advance. Push at count 2 cannot occur because f_ready_o=0.
- Latency: instruction accepted in cycle c is visible on d_valid_o in cycle c+2 when the downstream is not stalled. Throughput is 1 instruction/cycle.
- Flush (flush_i=1 at an edge): count=0, pointers=0, d_valid_o=0.
  - Flush takes priority over a same-cycle push, load or handshake; the fetch beat is dropped.
  - d_* data values need not be cleared.
- Illegal set: d_illegal_o=1 unless opcode is one of 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33, 0x73, 0x0F.
  - d_illegal_o is registered with the other d_* outputs.
  - An illegal instruction still flows through with d_imm_o = igen_imm_i (0 for an unknown opcode).
- Ordering: strictly in-order; no instruction is duplicated or lost except by flush or reset.

Optional Feature:
- Macro: DECODE_SCHED_BYPASS_EN.
- Defined: when count=0, the output register is free or draining (!d_valid_o || d_ready_i), a push occurs and !flush_i:
  - The fetch instruction bypasses the queue. igen_* are driven from f_insn_i that cycle, d_* load directly, and the queue is not written.
  - Latency becomes c+1.
  - igen_opcode_o/igen_insn_o are muxed between f_insn_i and the head (bypass only when count=0).
- Undefined: no bypass path; latency is always c+2 and igen_* are driven only from the queue head.

Test Plan:
- Reset then single push of pc=0x100, insn=0xFFF00093 (addi x1,x0,-1), d_ready_i=1, igen model returns 0xFFFFFFFF -> d_valid_o=1 exactly 2 cycles after accept (1 with bypass), with d_pc_o=0x100, d_imm_o=0xFFFFFFFF, d_rd_o=1, d_rs1_o=0, d_funct3_o=0, d_illegal_o=0.
- Back-to-back 8 pushes with d_ready_i=1 -> 8 consecutive d_valid_o cycles, PCs 0x100..0x11C in order, f_ready_o never drops.
- d_ready_i=0 held while pushing 4 instructions -> output holds insn0 stable, queue fills to 2, f_ready_o=0 thereafter, 4th push not accepted. Release d_ready_i -> insn0..3 delivered in order with no loss.
- Flush asserted with count=2 and d_valid_o=1 plus a same-cycle fetch beat -> next cycle d_valid_o=0, f_ready_o=1, the flushed beat never appears; the following push appears normally.
- Push insn 0x0000007F (opcode 0x7F) -> d_illegal_o=1, d_imm_o=0. Push 0x00000013 -> d_illegal_o=0.
- rst_n=0 for one cycle while count=1 and d_valid_o=1 -> next cycle d_valid_o=0, f_ready_o=1, all d_* data outputs=0.

Source files
------------

// File: rtl/decode_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_sched_if                                                            |
// | Fetch, immediate-generator and decode-output signals of decode_sched.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface decode_sched_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              f_valid_i;
    logic              f_ready_o;
    logic [AWIDTH-1:0] f_pc_i;
    logic [DWIDTH-1:0] f_insn_i;
    logic              flush_i;
    logic [6:0]        igen_opcode_o;
    logic [DWIDTH-1:0] igen_insn_o;
    logic [31:0]       igen_imm_i;
    logic              d_valid_o;
    logic              d_ready_i;
    logic [AWIDTH-1:0] d_pc_o;
    logic [DWIDTH-1:0] d_insn_o;
    logic [31:0]       d_imm_o;
    logic [4:0]        d_rd_o;
    logic [4:0]        d_rs1_o;
    logic [4:0]        d_rs2_o;
    logic [2:0]        d_funct3_o;
    logic [6:0]        d_funct7_o;
    logic              d_illegal_o;

    modport master (
        output f_valid_i, f_pc_i, f_insn_i, flush_i, igen_imm_i, d_ready_i,
        input  f_ready_o, igen_opcode_o, igen_insn_o, d_valid_o, d_pc_o, d_insn_o,
               d_imm_o, d_rd_o, d_rs1_o, d_rs2_o, d_funct3_o, d_funct7_o, d_illegal_o
    );

    modport slave (
        input  f_valid_i, f_pc_i, f_insn_i, flush_i, igen_imm_i, d_ready_i,
        output f_ready_o, igen_opcode_o, igen_insn_o, d_valid_o, d_pc_o, d_insn_o,
               d_imm_o, d_rd_o, d_rs1_o, d_rs2_o, d_funct3_o, d_funct7_o, d_illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/decode_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_sched                                                               |
// | Decode-stage scheduler: 2-entry fetch queue feeding a decode output reg.   |
// | Optional: DECODE_SCHED_BYPASS_EN lets an empty queue forward fetch direct. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decode_sched #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_sched_if.slave bus
);
    logic [1:0]        r_count;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [AWIDTH-1:0] r_q_pc   [2];
    logic [DWIDTH-1:0] r_q_insn [2];

    logic              r_d_valid;
    logic [AWIDTH-1:0] r_d_pc;
    logic [DWIDTH-1:0] r_d_insn;
    logic [31:0]       r_d_imm;
    logic              r_d_illegal;

    logic              w_f_ready;
    logic              w_push;
    logic              w_out_free;
    logic              w_q_nonempty;
    logic              w_bypass;
    logic              w_pop;
    logic              w_load;
    logic              w_q_write;
    logic [AWIDTH-1:0] w_src_pc;
    logic [DWIDTH-1:0] w_src_insn;

    function automatic logic f_is_legal(input logic [6:0] opcode);
        case (opcode)
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h73, 7'h0F: f_is_legal = 1'b1;
            default:                           f_is_legal = 1'b0;
        endcase
    endfunction

    assign w_f_ready    = (r_count != 2'd2);
    assign w_push       = bus.f_valid_i && w_f_ready && !bus.flush_i;
    assign w_out_free   = !r_d_valid || bus.d_ready_i;
    assign w_q_nonempty = (r_count != 2'd0);

`ifdef DECODE_SCHED_BYPASS_EN
    assign w_bypass = !w_q_nonempty && w_out_free && w_push;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop     = w_q_nonempty && w_out_free && !bus.flush_i;
    assign w_load    = w_pop || w_bypass;
    assign w_q_write = w_push && !w_bypass;

    // Source of the next decode entry: queue head, or the live fetch beat on bypass.
    always_comb begin
        w_src_pc   = r_q_pc[r_rd_ptr];
        w_src_insn = r_q_insn[r_rd_ptr];
        if (w_bypass) begin
            w_src_pc   = bus.f_pc_i;
            w_src_insn = bus.f_insn_i;
        end
    end

    assign bus.f_ready_o     = w_f_ready;
    assign bus.igen_insn_o   = (w_q_nonempty || w_bypass) ? w_src_insn : '0;
    assign bus.igen_opcode_o = bus.igen_insn_o[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]   <= '0;
                r_q_insn[i] <= '0;
            end
        end else if (bus.flush_i) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_q_write) begin
                r_q_pc[r_wr_ptr]   <= bus.f_pc_i;
                r_q_insn[r_wr_ptr] <= bus.f_insn_i;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_q_write) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d_valid   <= 1'b0;
            r_d_pc      <= '0;
            r_d_insn    <= '0;
            r_d_imm     <= '0;
            r_d_illegal <= 1'b0;
        end else if (bus.flush_i) begin
            r_d_valid <= 1'b0;
        end else if (w_load) begin
            r_d_valid   <= 1'b1;
            r_d_pc      <= w_src_pc;
            r_d_insn    <= w_src_insn;
            r_d_imm     <= bus.igen_imm_i;
            r_d_illegal <= !f_is_legal(w_src_insn[6:0]);
        end else if (r_d_valid && bus.d_ready_i) begin
            r_d_valid <= 1'b0;
        end
    end

    // Field outputs are fixed slices of the registered instruction.
    assign bus.d_valid_o   = r_d_valid;
    assign bus.d_pc_o      = r_d_pc;
    assign bus.d_insn_o    = r_d_insn;
    assign bus.d_imm_o     = r_d_imm;
    assign bus.d_illegal_o = r_d_illegal;
    assign bus.d_rd_o      = r_d_insn[11:7];
    assign bus.d_rs1_o     = r_d_insn[19:15];
    assign bus.d_rs2_o     = r_d_insn[24:20];
    assign bus.d_funct3_o  = r_d_insn[14:12];
    assign bus.d_funct7_o  = r_d_insn[31:25];
endmodule
`default_nettype wire

// File: tb/tb_decode_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode_sched                                                            |
// | Directed and random stimulus against an in-order transaction model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decode_sched;
    localparam int DW = 32;
    localparam int AW = 32;
`ifdef DECODE_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [6:0] LEGAL_OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                              7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_sched_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
    decode_sched #(.DWIDTH(DW), .AWIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // External immediate generator: standard RV32I immediate by format, 0 otherwise.
    function automatic logic [31:0] igen_model(input logic [31:0] insn);
        case (insn[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: igen_model = {{20{insn[31]}}, insn[31:20]};
            7'h23: igen_model = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            7'h63: igen_model = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            7'h37, 7'h17: igen_model = {insn[31:12], 12'b0};
            7'h6F: igen_model = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: igen_model = 32'h0;
        endcase
    endfunction

    always_comb bus.igen_imm_i = igen_model(bus.igen_insn_o);

    function automatic bit ref_legal(input logic [6:0] op);
        ref_legal = 1'b0;
        foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) ref_legal = 1'b1;
    endfunction

    typedef struct { logic [31:0] pc; logic [31:0] insn; } item_t;
    item_t model_q[$];   // every accepted, undelivered instruction in order
    bit    m_dv;         // model: decode output register holds model_q[0]

    int n_checks = 0;
    int n_fail   = 0;
    int delivered;
    bit s_dvalid, s_fready, p_hold;
    logic [31:0] p_pc, p_insn, p_imm, l_pc, l_imm;
    logic        l_illegal;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] insn,
                        input bit fl, input bit dr, output bit acc);
        int qc;
        bit out_free, hs, byp, nxt_dv;
        logic [31:0] exp_ig;
        item_t e;
        @(negedge clk);
        bus.f_valid_i = fv;
        bus.f_pc_i    = pc;
        bus.f_insn_i  = insn;
        bus.flush_i   = fl;
        bus.d_ready_i = dr;
        #1;
        qc       = model_q.size() - int'(m_dv);
        out_free = !m_dv || dr;
        acc      = fv && (qc != 2) && !fl;
        byp      = BYP && acc && (qc == 0) && out_free;
        check("d_valid", 64'(bus.d_valid_o), 64'(m_dv));
        check("f_ready", 64'(bus.f_ready_o), 64'(qc != 2));
        exp_ig = (qc > 0) ? model_q[m_dv ? 1 : 0].insn : (byp ? insn : 32'h0);
        check("igen_insn", 64'(bus.igen_insn_o), 64'(exp_ig));
        check("igen_opcode", 64'(bus.igen_opcode_o), 64'(exp_ig[6:0]));
        if (p_hold) begin
            check("hold_pc_insn", {bus.d_pc_o, bus.d_insn_o}, {p_pc, p_insn});
            check("hold_imm", 64'(bus.d_imm_o), 64'(p_imm));
        end
        hs = m_dv && dr && !fl;
        if (hs) begin
            if (model_q.size() == 0) begin
                check("unexpected_delivery", 64'd1, 64'd0);
            end else begin
                e = model_q.pop_front();
                check("d_pc", 64'(bus.d_pc_o), 64'(e.pc));
                check("d_insn", 64'(bus.d_insn_o), 64'(e.insn));
                check("d_imm", 64'(bus.d_imm_o), 64'(igen_model(e.insn)));
                check("d_fields", 64'({bus.d_rd_o, bus.d_rs1_o, bus.d_rs2_o, bus.d_funct3_o, bus.d_funct7_o}),
                      64'({e.insn[11:7], e.insn[19:15], e.insn[24:20], e.insn[14:12], e.insn[31:25]}));
                check("d_illegal", 64'(bus.d_illegal_o), 64'(!ref_legal(e.insn[6:0])));
            end
            delivered++;
            l_pc      = bus.d_pc_o;
            l_imm     = bus.d_imm_o;
            l_illegal = bus.d_illegal_o;
        end
        p_hold = m_dv && !dr && !fl;
        p_pc   = bus.d_pc_o;
        p_insn = bus.d_insn_o;
        p_imm  = bus.d_imm_o;
        if (fl)            nxt_dv = 1'b0;
        else if (out_free) nxt_dv = (qc > 0) || byp;
        else               nxt_dv = 1'b1;
        if (fl) model_q.delete();
        else if (acc) model_q.push_back('{pc: pc, insn: insn});
        m_dv     = nxt_dv;
        s_dvalid = bus.d_valid_o;
        s_fready = bus.f_ready_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.f_valid_i = 1'b0;
        bus.flush_i   = 1'b0;
        bus.d_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        m_dv   = 1'b0;
        p_hold = 1'b0;
        #1;
        check("rst_d_valid", 64'(bus.d_valid_o), 64'd0);
        check("rst_f_ready", 64'(bus.f_ready_o), 64'd1);
        check("rst_d_pc_insn", {bus.d_pc_o, bus.d_insn_o}, 64'd0);
        check("rst_d_imm", 64'(bus.d_imm_o), 64'd0);
        check("rst_d_illegal", 64'(bus.d_illegal_o), 64'd0);
        check("rst_fields", 64'({bus.d_rd_o, bus.d_rs1_o, bus.d_rs2_o, bus.d_funct3_o, bus.d_funct7_o}), 64'd0);
    endtask

    function automatic logic [31:0] addi(input int k);
        addi = {12'(k), 5'd2, 3'b000, 5'(k + 1), 7'h13};
    endfunction

    initial begin
        bit acc;
        int k, vcnt;
        logic [31:0] r, pc;
        rst_n = 1'b0;
        bus.f_valid_i = 1'b0;
        bus.f_pc_i    = '0;
        bus.f_insn_i  = '0;
        bus.flush_i   = 1'b0;
        bus.d_ready_i = 1'b0;
        m_dv = 1'b0;
        p_hold = 1'b0;
        delivered = 0;
        do_reset();

        // Single instruction: latency and decoded contents.
        step(1'b1, 32'h100, 32'hFFF00093, 1'b0, 1'b1, acc);
        check("t1_accept", 64'(acc), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t1_valid_c1", 64'(s_dvalid), 64'(BYP));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t1_valid_c2", 64'(s_dvalid), 64'(!BYP));
        check("t1_pc", 64'(l_pc), 64'h100);
        check("t1_imm", 64'(l_imm), 64'hFFFFFFFF);
        check("t1_illegal", 64'(l_illegal), 64'd0);

        // Eight back-to-back instructions at full throughput.
        delivered = 0;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), addi(i), 1'b0, 1'b1, acc);
            check("t2_accept", 64'(acc), 64'd1);
            vcnt += int'(s_dvalid);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
            vcnt += int'(s_dvalid);
        end
        check("t2_delivered", 64'(delivered), 64'd8);
        check("t2_valid_cycles", 64'(vcnt), 64'd8);

        // Downstream stall: only three of four beats fit.
        delivered = 0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h200 + 32'(4 * k), addi(k + 20), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        check("t3_accepted", 64'(k), 64'd3);
        check("t3_f_ready_low", 64'(s_fready), 64'd0);
        for (int i = 0; i < 20 && k < 4; i++) begin
            step(1'b1, 32'h200 + 32'(4 * k), addi(k + 20), 1'b0, 1'b1, acc);
            if (acc) k++;
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t3_delivered", 64'(delivered), 64'd4);

        // Flush with a full queue, a stalled output and a same-cycle fetch beat.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), addi(i + 40), 1'b0, 1'b0, acc);
        check("t4_full", 64'(model_q.size()), 64'd3);
        step(1'b1, 32'h3FC, addi(50), 1'b1, 1'b1, acc);
        delivered = 0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t4_valid_after_flush", 64'(s_dvalid), 64'd0);
        check("t4_ready_after_flush", 64'(s_fready), 64'd1);
        step(1'b1, 32'h400, addi(60), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t4_delivered", 64'(delivered), 64'd1);
        check("t4_pc", 64'(l_pc), 64'h400);

        // Illegal and legal opcodes.
        step(1'b1, 32'h500, 32'h0000007F, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t5_illegal", 64'(l_illegal), 64'd1);
        check("t5_imm", 64'(l_imm), 64'd0);
        step(1'b1, 32'h504, 32'h00000013, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("t5_legal", 64'(l_illegal), 64'd0);

        // Reset with one queued entry and a valid output.
        step(1'b1, 32'h600, addi(70), 1'b0, 1'b0, acc);
        step(1'b1, 32'h604, addi(71), 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        check("t6_pre_valid", 64'(s_dvalid), 64'd1);
        do_reset();

        // Random traffic.
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 7) == 0) r = $urandom;
            else r = {r[31:7], LEGAL_OPS[$urandom_range(0, 10)]};
            step($urandom_range(0, 9) < 7, pc, r, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7, acc);
            if (acc) pc += 32'd4;
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("drain_empty", 64'(model_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
